// File: rtl/con_ff_unit_pkg.sv
// Shared types and defaults for the branch-condition unit.
package con_ff_unit_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_CNT_W  = 16;

    // Condition field decoding; 9..15 are reserved and flag bad_mode.
    typedef enum logic [3:0] {
        COND_EQ     = 4'd0,
        COND_NE     = 4'd1,
        COND_GE     = 4'd2,
        COND_LT     = 4'd3,
        COND_GT     = 4'd4,
        COND_LE     = 4'd5,
        COND_ALWAYS = 4'd6,
        COND_NEVER  = 4'd7,
        COND_DBNZ   = 4'd8,
        COND_RSV_LO = 4'd9,
        COND_RSV_HI = 4'd15
    } condMode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_HOLD = 2'd2
    } fsmState_e;

endpackage

// File: rtl/con_ff_unit_if.sv
// Bus/control-unit side signals of the branch-condition unit.
interface con_ff_unit_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic [DATA_W-1:0] bus_in;
    logic [3:0]        ir_cond;
    logic              con_in;
    logic              cnt_load;
    logic              branch_ack;
    logic              con_out;
    logic              con_valid;
    logic              cnt_zero;
    logic              overrun;
    logic              bad_mode;

    // Control unit / bus mux side.
    modport master (
        output bus_in, ir_cond, con_in, cnt_load, branch_ack,
        input  con_out, con_valid, cnt_zero, overrun, bad_mode
    );

    // Condition unit side.
    modport slave (
        input  bus_in, ir_cond, con_in, cnt_load, branch_ack,
        output con_out, con_valid, cnt_zero, overrun, bad_mode
    );
endinterface

// File: rtl/con_ff_unit_con_eval.sv
// Purely combinational condition evaluator: {taken, badMode} from operand, mode and loop count.
module con_eval
    import con_ff_unit_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic signed [DATA_W-1:0] operand,
    input  condMode_e                mode,
    input  logic        [CNT_W-1:0]  count,
    output logic                     taken,
    output logic                     badMode
);
    logic isZero;
    logic isNeg;

    assign isZero = (operand == '0);
    assign isNeg  = (operand < 0);

    // Decode the selected condition; DBNZ branches while the pre-decrement count exceeds one.
    always_comb begin
        taken   = 1'b0;
        badMode = 1'b0;
        case (mode)
            COND_EQ:     taken = isZero;
            COND_NE:     taken = !isZero;
            COND_GE:     taken = !isNeg;
            COND_LT:     taken = isNeg;
            COND_GT:     taken = !isNeg && !isZero;
            COND_LE:     taken = isNeg || isZero;
            COND_ALWAYS: taken = 1'b1;
            COND_NEVER:  taken = 1'b0;
            COND_DBNZ:   taken = (count != '0) && (count != CNT_W'(1));
            default: begin
                taken   = 1'b0;
                badMode = 1'b1;
            end
        endcase
    end
endmodule

// File: rtl/con_ff_unit.sv
// Branch-condition unit: strobe-edge triggered evaluation, held result with ack handshake,
// decrement-and-branch loop counter and sticky overrun reporting.
module con_ff_unit
    import con_ff_unit_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic          clock,
    input  logic          clear,
    con_ff_unit_if.slave  bus
);
    fsmState_e               state;
    logic                    conInPrev;
    logic                    armed;
    logic                    strobeEdge;
    logic signed [DATA_W-1:0] busHeld_p0;
    condMode_e               modeHeld_p0;
    logic [CNT_W-1:0]        cntReg;
    logic                    conOutReg;
    logic                    conValidReg;
    logic                    overrunReg;
    logic                    badModeReg;
    logic                    evalTaken;
    logic                    evalBad;

    // armed keeps a level already high at reset release from looking like a rising edge.
    assign strobeEdge = armed && bus.con_in && !conInPrev;

    con_eval #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_eval (
        .operand (busHeld_p0),
        .mode    (modeHeld_p0),
        .count   (cntReg),
        .taken   (evalTaken),
        .badMode (evalBad)
    );

    // Edge detector, sequencer and registered result/status flags.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state       <= ST_IDLE;
            conInPrev   <= 1'b0;
            armed       <= 1'b0;
            conOutReg   <= 1'b0;
            conValidReg <= 1'b0;
            overrunReg  <= 1'b0;
            badModeReg  <= 1'b0;
        end else begin
            armed     <= 1'b1;
            conInPrev <= bus.con_in;
            if (strobeEdge && state != ST_IDLE)
                overrunReg <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (strobeEdge)
                        state <= ST_EVAL;
                end
                ST_EVAL: begin
                    conOutReg   <= evalTaken;
                    badModeReg  <= evalBad;
                    conValidReg <= 1'b1;
                    state       <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.branch_ack) begin
                        conValidReg <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // p0: operands captured on the accepted strobe edge, consumed in EVAL.
    always_ff @(posedge clock) begin
        if (state == ST_IDLE && strobeEdge) begin
            busHeld_p0  <= bus.bus_in;
            modeHeld_p0 <= condMode_e'(bus.ir_cond);
        end
    end

    // Loop counter: an explicit load overrides the DBNZ decrement, which saturates at zero.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear)
            cntReg <= '0;
        else if (bus.cnt_load)
            cntReg <= bus.bus_in[CNT_W-1:0];
        else if (state == ST_EVAL && modeHeld_p0 == COND_DBNZ && cntReg != '0)
            cntReg <= cntReg - CNT_W'(1);
    end

    assign bus.con_out   = conOutReg;
    assign bus.con_valid = conValidReg;
    assign bus.cnt_zero  = (cntReg == '0);
    assign bus.overrun   = overrunReg;
    assign bus.bad_mode  = badModeReg;
endmodule

// File: tb/tb_con_ff_unit.sv
// Directed bench for con_ff_unit: each scenario task drives vectors and checks hand-computed results.
module tb_con_ff_unit;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    logic clock;
    logic clear;
    int   nVec;
    int   nErr;

    con_ff_unit_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) ffIf ();

    con_ff_unit #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (ffIf.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Raise the strobe with operands, drop it; result is visible after the second edge.
    task automatic doStrobe(input logic [DATA_W-1:0] val, input logic [3:0] mode);
        ffIf.bus_in  = val;
        ffIf.ir_cond = mode;
        ffIf.con_in  = 1'b1;
        tick();
        ffIf.con_in  = 1'b0;
        tick();
    endtask

    task automatic doAck();
        ffIf.branch_ack = 1'b1;
        tick();
        ffIf.branch_ack = 1'b0;
    endtask

    task automatic doLoad(input logic [DATA_W-1:0] val);
        ffIf.bus_in   = val;
        ffIf.cnt_load = 1'b1;
        tick();
        ffIf.cnt_load = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b0;
        ffIf.bus_in = '0; ffIf.ir_cond = '0; ffIf.con_in = 1'b0;
        ffIf.cnt_load = 1'b0; ffIf.branch_ack = 1'b0;
        tick(); tick();
        nVec++;
        if ({ffIf.con_out, ffIf.con_valid, ffIf.overrun, ffIf.bad_mode, ffIf.cnt_zero} !== 5'b00001) begin
            nErr++;
            $display("FAIL reset_outputs got %b want 00001",
                     {ffIf.con_out, ffIf.con_valid, ffIf.overrun, ffIf.bad_mode, ffIf.cnt_zero});
        end
        #3 clear = 1'b1;
        tick();
    endtask

    task automatic test_eq_latency();
        ffIf.bus_in = '0; ffIf.ir_cond = 4'd0; ffIf.con_in = 1'b1;
        tick();
        nVec++;
        if (ffIf.con_valid !== 1'b0) begin
            nErr++; $display("FAIL eq_early_valid got %b want 0", ffIf.con_valid);
        end
        ffIf.con_in = 1'b0;
        tick();
        nVec++;
        if ({ffIf.con_out, ffIf.con_valid} !== 2'b11) begin
            nErr++; $display("FAIL eq_result got %b want 11", {ffIf.con_out, ffIf.con_valid});
        end
        tick(); tick();
        nVec++;
        if ({ffIf.con_out, ffIf.con_valid} !== 2'b11) begin
            nErr++; $display("FAIL eq_hold got %b want 11", {ffIf.con_out, ffIf.con_valid});
        end
        doAck();
        nVec++;
        if (ffIf.con_valid !== 1'b0) begin
            nErr++; $display("FAIL eq_ack_valid got %b want 0", ffIf.con_valid);
        end
    endtask

    task automatic test_compare();
        logic [DATA_W-1:0] vals [10];
        logic [3:0]        modes [10];
        logic              exps [10];
        vals = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h1,
                 32'h1, 32'h5, 32'h0, 32'hFFFF_FFFF, 32'h0};
        modes = '{4'd3, 4'd2, 4'd5, 4'd4, 4'd1, 4'd0, 4'd4, 4'd5, 4'd6, 4'd7};
        exps  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 10; i++) begin
            doStrobe(vals[i], modes[i]);
            nVec++;
            if ({ffIf.con_out, ffIf.con_valid, ffIf.bad_mode} !== {exps[i], 1'b1, 1'b0}) begin
                nErr++;
                $display("FAIL compare[%0d] mode %0d bus %h got out/valid/bad %b want %b",
                         i, modes[i], vals[i], {ffIf.con_out, ffIf.con_valid, ffIf.bad_mode},
                         {exps[i], 1'b1, 1'b0});
            end
            doAck();
        end
    endtask

    task automatic test_dbnz();
        logic expOut [4];
        logic expZero [4];
        expOut  = '{1'b1, 1'b1, 1'b0, 1'b0};
        expZero = '{1'b0, 1'b0, 1'b1, 1'b1};
        doLoad(32'd3);
        nVec++;
        if (ffIf.cnt_zero !== 1'b0) begin
            nErr++; $display("FAIL dbnz_load_zero got %b want 0", ffIf.cnt_zero);
        end
        for (int i = 0; i < 4; i++) begin
            doStrobe(32'h0, 4'd8);
            nVec++;
            if ({ffIf.con_out, ffIf.cnt_zero} !== {expOut[i], expZero[i]}) begin
                nErr++;
                $display("FAIL dbnz[%0d] got out/zero %b want %b", i,
                         {ffIf.con_out, ffIf.cnt_zero}, {expOut[i], expZero[i]});
            end
            doAck();
        end
    endtask

    task automatic test_bad_mode();
        doStrobe(32'h0, 4'd12);
        nVec++;
        if ({ffIf.con_out, ffIf.bad_mode} !== 2'b01) begin
            nErr++; $display("FAIL bad_mode_rsv got out/bad %b want 01", {ffIf.con_out, ffIf.bad_mode});
        end
        doAck();
        doStrobe(32'h0, 4'd6);
        nVec++;
        if ({ffIf.con_out, ffIf.bad_mode} !== 2'b10) begin
            nErr++; $display("FAIL bad_mode_clear got out/bad %b want 10", {ffIf.con_out, ffIf.bad_mode});
        end
        doAck();
    endtask

    task automatic test_load_vs_dbnz();
        doLoad(32'd1);
        // Strobe DBNZ, then load 2 on the EVAL edge: load must win over the decrement.
        ffIf.ir_cond = 4'd8; ffIf.con_in = 1'b1;
        tick();
        ffIf.con_in = 1'b0;
        ffIf.bus_in = 32'd2; ffIf.cnt_load = 1'b1;
        tick();
        ffIf.cnt_load = 1'b0;
        nVec++;
        if ({ffIf.con_out, ffIf.cnt_zero} !== 2'b00) begin
            nErr++; $display("FAIL load_wins got out/zero %b want 00", {ffIf.con_out, ffIf.cnt_zero});
        end
        doAck();
        doStrobe(32'h0, 4'd8);
        nVec++;
        if ({ffIf.con_out, ffIf.cnt_zero} !== 2'b10) begin
            nErr++; $display("FAIL load_wins_dbnz1 got out/zero %b want 10", {ffIf.con_out, ffIf.cnt_zero});
        end
        doAck();
        doStrobe(32'h0, 4'd8);
        nVec++;
        if ({ffIf.con_out, ffIf.cnt_zero} !== 2'b01) begin
            nErr++; $display("FAIL load_wins_dbnz2 got out/zero %b want 01", {ffIf.con_out, ffIf.cnt_zero});
        end
        doAck();
    endtask

    task automatic test_overrun();
        doStrobe(32'h0, 4'd0);
        // Second edge while holding: operands would give 0 if it were taken.
        doStrobe(32'h5, 4'd0);
        nVec++;
        if ({ffIf.con_out, ffIf.con_valid, ffIf.overrun} !== 3'b111) begin
            nErr++;
            $display("FAIL overrun_hold got out/valid/ovr %b want 111",
                     {ffIf.con_out, ffIf.con_valid, ffIf.overrun});
        end
        doAck();
        doStrobe(32'h0, 4'd7);
        nVec++;
        if ({ffIf.con_out, ffIf.overrun} !== 2'b01) begin
            nErr++; $display("FAIL overrun_sticky got out/ovr %b want 01", {ffIf.con_out, ffIf.overrun});
        end
        doAck();
    endtask

    task automatic test_held_high();
        ffIf.bus_in = '0; ffIf.ir_cond = 4'd6; ffIf.con_in = 1'b1;
        tick(); tick();
        doAck();
        tick(); tick(); tick();
        nVec++;
        if (ffIf.con_valid !== 1'b0) begin
            nErr++; $display("FAIL held_high_retrigger got valid %b want 0", ffIf.con_valid);
        end
        ffIf.con_in = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        doLoad(32'd4);
        doStrobe(32'h0, 4'd0);
        nVec++;
        if ({ffIf.con_valid, ffIf.overrun, ffIf.cnt_zero} !== 3'b110) begin
            nErr++; $display("FAIL pre_reset got valid/ovr/zero %b want 110",
                             {ffIf.con_valid, ffIf.overrun, ffIf.cnt_zero});
        end
        ffIf.con_in = 1'b1;
        #2 clear = 1'b0;
        #1;
        nVec++;
        if ({ffIf.con_out, ffIf.con_valid, ffIf.overrun, ffIf.bad_mode, ffIf.cnt_zero} !== 5'b00001) begin
            nErr++;
            $display("FAIL async_reset got %b want 00001",
                     {ffIf.con_out, ffIf.con_valid, ffIf.overrun, ffIf.bad_mode, ffIf.cnt_zero});
        end
        tick();
        #2 clear = 1'b1;
        tick(); tick(); tick();
        nVec++;
        if (ffIf.con_valid !== 1'b0) begin
            nErr++; $display("FAIL reset_release_level got valid %b want 0", ffIf.con_valid);
        end
        ffIf.con_in = 1'b0;
        tick();
        doStrobe(32'h0, 4'd1);
        nVec++;
        if ({ffIf.con_out, ffIf.con_valid} !== 2'b01) begin
            nErr++; $display("FAIL post_reset_eval got out/valid %b want 01", {ffIf.con_out, ffIf.con_valid});
        end
        doAck();
    endtask

    initial begin
        nVec = 0;
        nErr = 0;
        test_reset();
        test_eq_latency();
        test_compare();
        test_dbnz();
        test_bad_mode();
        test_load_vs_dbnz();
        test_overrun();
        test_held_high();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
